// File: rtl/stats_pkg.sv
// rtl/stats_pkg.sv - shared constants and types for the statistics counter bank
//
// Contents:
//    DEF_NUM_CNT, DEF_CNT_WIDTH, DEF_ADDR_WIDTH : default bank geometry
//    sat_mode_e                                 : counter overflow behaviour (WRAP / SAT)
package stats_pkg;

   localparam int DEF_NUM_CNT    = 8;
   localparam int DEF_CNT_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH = 6;

   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } sat_mode_e;

endpackage

// File: rtl/stats_cntr_bank_if.sv
// rtl/stats_cntr_bank_if.sv - host read port of the statistics counter bank
//
// Signals:
//    i_rd_req   : single-cycle read request
//    i_rd_addr  : channel to read
//    i_rd_clr   : qualifies i_rd_req as read-and-clear
//    o_rd_data  : read result, held while o_rd_vld is low
//    o_rd_vld   : one-cycle strobe, one cycle after i_rd_req
//    o_rd_err   : accompanies o_rd_vld for an out-of-range address
// Modports: master = host side, slave = counter bank side.
interface stats_cntr_bank_if #(
   parameter int ADDR_WIDTH = stats_pkg::DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = stats_pkg::DEF_CNT_WIDTH
);

   logic                  i_rd_req;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic                  i_rd_clr;
   logic [CNT_WIDTH-1:0]  o_rd_data;
   logic                  o_rd_vld;
   logic                  o_rd_err;

   modport master (
      output i_rd_req, i_rd_addr, i_rd_clr,
      input  o_rd_data, o_rd_vld, o_rd_err
   );

   modport slave (
      input  i_rd_req, i_rd_addr, i_rd_clr,
      output o_rd_data, o_rd_vld, o_rd_err
   );

endinterface

// File: rtl/stats_cntr.sv
// rtl/stats_cntr.sv - single event counter with wrap/saturate and sticky overflow
//
// Ports:
//    clk, reset : clock, synchronous active-low reset
//    inc        : count one event this cycle
//    clr        : clear counter and overflow flag (an event in the same cycle is kept)
//    sat_mode   : WRAP -> roll over to zero at all ones, SAT -> hold at all ones
//    val        : current count
//    ovf        : sticky flag, set when an increment hits the all-ones value
module stats_cntr
   import stats_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 clr,
   input  sat_mode_e            sat_mode,
   output logic [CNT_WIDTH-1:0] val,
   output logic                 ovf
);

   logic [CNT_WIDTH-1:0] val_q, val_d;
   logic                 ovf_q, ovf_d;

   always_comb begin
      val_d = val_q;
      ovf_d = ovf_q;
      if (clr) begin
         // The coincident event survives the clear so no count is lost.
         val_d = {{(CNT_WIDTH-1){1'b0}}, inc};
         ovf_d = 1'b0;
      end else if (inc) begin
         if (&val_q) begin
            ovf_d = 1'b1;
            if (sat_mode == WRAP) begin
               val_d = '0;
            end
         end else begin
            val_d = val_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         val_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         val_q <= val_d;
         ovf_q <= ovf_d;
      end
   end

   assign val = val_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/stats_cntr_bank.sv
// rtl/stats_cntr_bank.sv - bank of event counters with a one-cycle host read port
//
// Ports:
//    gtx_clk   : clock
//    reset     : synchronous active-low reset
//    i_inc     : per-channel increment strobes
//    i_clr_all : clear all counters and overflow flags (beats increments and read-clear)
//    rd_if     : host read port (slave side of stats_cntr_bank_if)
//    o_ovf     : per-channel sticky overflow flags
module stats_cntr_bank
   import stats_pkg::*;
#(
   parameter int NUM_CNT    = DEF_NUM_CNT,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int SAT_MODE   = 0,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic               gtx_clk,
   input  logic               reset,
   input  logic [NUM_CNT-1:0] i_inc,
   input  logic               i_clr_all,
   stats_cntr_bank_if.slave   rd_if,
   output logic [NUM_CNT-1:0] o_ovf
);

   localparam sat_mode_e              SAT_SEL   = (SAT_MODE == 1) ? SAT : WRAP;
   // One extra bit so NUM_CNT == 2**ADDR_WIDTH is still representable.
   localparam logic [ADDR_WIDTH:0]    NUM_CNT_A = (ADDR_WIDTH+1)'(NUM_CNT);

   logic                 addr_ok;
   logic                 rd_clr_req;
   logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
   logic [CNT_WIDTH-1:0] rd_val;

   logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                 rd_vld_q, rd_vld_d;
   logic                 rd_err_q, rd_err_d;

   assign addr_ok    = ({1'b0, rd_if.i_rd_addr} < NUM_CNT_A);
   // Out-of-range read-and-clear must not touch any counter.
   assign rd_clr_req = rd_if.i_rd_req & rd_if.i_rd_clr & addr_ok;

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      logic hit;
      assign hit = rd_clr_req && (rd_if.i_rd_addr == ADDR_WIDTH'(g));

      stats_cntr #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cntr (
         .clk      (gtx_clk),
         .reset    (reset),
         .inc      (i_inc[g] & ~i_clr_all),
         .clr      (i_clr_all | hit),
         .sat_mode (SAT_SEL),
         .val      (cnt_val[g]),
         .ovf      (o_ovf[g])
      );
   end

   // Mux samples the registered counter, i.e. the value before this cycle's update.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (rd_if.i_rd_addr == ADDR_WIDTH'(i)) begin
            rd_val = cnt_val[i];
         end
      end
   end

   always_comb begin
      rd_vld_d  = rd_if.i_rd_req;
      rd_err_d  = rd_if.i_rd_req & ~addr_ok;
      rd_data_d = rd_data_q;
      if (rd_if.i_rd_req) begin
         rd_data_d = addr_ok ? rd_val : '0;
      end
   end

   always_ff @(posedge gtx_clk) begin
      if (!reset) begin
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
         rd_err_q  <= 1'b0;
      end else begin
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
         rd_err_q  <= rd_err_d;
      end
   end

   assign rd_if.o_rd_data = rd_data_q;
   assign rd_if.o_rd_vld  = rd_vld_q;
   assign rd_if.o_rd_err  = rd_err_q;

endmodule

// File: tb/tb_stats_cntr_bank.sv
// tb/tb_stats_cntr_bank.sv - directed self-checking bench for stats_cntr_bank
module tb_stats_cntr_bank;

   localparam int NC = 8;
   localparam int CW = 8;
   localparam int AW = 6;

   typedef struct {
      logic [NC-1:0] inc;
      logic          req;
      logic [AW-1:0] addr;
      logic          clr;
      logic          vld;
      logic          err;
      logic [CW-1:0] data;
   } vec_t;

   logic          gtx_clk = 1'b0;
   logic          reset;
   logic [NC-1:0] inc;
   logic          clr_all;
   logic [NC-1:0] ovf_w, ovf_s;
   int            n_tests = 0;
   int            n_fail  = 0;
   vec_t          vt [17];

   always #5 gtx_clk = ~gtx_clk;

   stats_cntr_bank_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) if_w ();
   stats_cntr_bank_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) if_s ();

   stats_cntr_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .SAT_MODE(0), .ADDR_WIDTH(AW)) dut_w (
      .gtx_clk(gtx_clk), .reset(reset), .i_inc(inc), .i_clr_all(clr_all),
      .rd_if(if_w), .o_ovf(ovf_w));

   stats_cntr_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .SAT_MODE(1), .ADDR_WIDTH(AW)) dut_s (
      .gtx_clk(gtx_clk), .reset(reset), .i_inc(inc), .i_clr_all(clr_all),
      .rd_if(if_s), .o_ovf(ovf_s));

   task automatic tick();
      @(posedge gtx_clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_rd(input logic req, input logic [AW-1:0] addr, input logic clr);
      if_w.i_rd_req = req; if_w.i_rd_addr = addr; if_w.i_rd_clr = clr;
      if_s.i_rd_req = req; if_s.i_rd_addr = addr; if_s.i_rd_clr = clr;
   endtask

   task automatic rd_chk(input string nm, input logic [AW-1:0] addr, input logic clr,
                         input logic [CW-1:0] exp_w, input logic [CW-1:0] exp_s);
      set_rd(1'b1, addr, clr);
      tick();
      set_rd(1'b0, '0, 1'b0);
      check({nm, " vld_w"},  64'(if_w.o_rd_vld),  64'd1);
      check({nm, " err_w"},  64'(if_w.o_rd_err),  64'd0);
      check({nm, " data_w"}, 64'(if_w.o_rd_data), 64'(exp_w));
      check({nm, " vld_s"},  64'(if_s.o_rd_vld),  64'd1);
      check({nm, " data_s"}, 64'(if_s.o_rd_data), 64'(exp_s));
   endtask

   task automatic rd_all_zero(input string nm);
      for (int c = 0; c < NC; c++) begin
         rd_chk($sformatf("%s ch%0d", nm, c), AW'(c), 1'b0, '0, '0);
      end
   endtask

   function automatic vec_t mk(input logic [NC-1:0] i, input logic r, input logic [AW-1:0] a,
                               input logic c, input logic v, input logic e, input logic [CW-1:0] d);
      vec_t t;
      t.inc = i; t.req = r; t.addr = a; t.clr = c; t.vld = v; t.err = e; t.data = d;
      return t;
   endfunction

   initial begin
      // inc, req, addr, clr  ->  vld, err, data   (state starts all zero)
      vt[0]  = mk(8'h04, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      vt[1]  = mk(8'h04, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      vt[2]  = mk(8'h04, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      vt[3]  = mk(8'h04, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      vt[4]  = mk(8'h04, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0);  // ch2 = 5
      vt[5]  = mk(8'h04, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0, 8'd5);  // rd-clr + inc -> ch2 = 1
      vt[6]  = mk(8'h00, 1'b1, 6'd2, 1'b0, 1'b1, 1'b0, 8'd1);
      vt[7]  = mk(8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd1);  // data held
      vt[8]  = mk(8'h81, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd1);  // ch0 = 1, ch7 = 1
      vt[9]  = mk(8'h01, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 8'd1);  // pre-increment value
      vt[10] = mk(8'h00, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 8'd2);  // back-to-back
      vt[11] = mk(8'h00, 1'b1, 6'd9, 1'b0, 1'b1, 1'b1, 8'd0);  // out of range
      vt[12] = mk(8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      vt[13] = mk(8'h00, 1'b1, 6'd7, 1'b1, 1'b1, 1'b0, 8'd1);  // rd-clr ch7 -> 0
      vt[14] = mk(8'h00, 1'b1, 6'd7, 1'b0, 1'b1, 1'b0, 8'd0);
      vt[15] = mk(8'h00, 1'b1, 6'd9, 1'b1, 1'b1, 1'b1, 8'd0);  // out-of-range rd-clr
      vt[16] = mk(8'h00, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 8'd2);  // ch0 untouched

      // Reset with a pending read and increments that must be ignored.
      reset = 1'b0; inc = '1; clr_all = 1'b0;
      set_rd(1'b1, 6'd0, 1'b0);
      tick(); tick(); tick();
      reset = 1'b1; inc = '0;
      set_rd(1'b0, '0, 1'b0);
      tick();
      check("reset vld_w",  64'(if_w.o_rd_vld),  64'd0);
      check("reset err_w",  64'(if_w.o_rd_err),  64'd0);
      check("reset data_w", 64'(if_w.o_rd_data), 64'd0);
      check("reset ovf_w",  64'(ovf_w),          64'd0);
      check("reset vld_s",  64'(if_s.o_rd_vld),  64'd0);
      check("reset ovf_s",  64'(ovf_s),          64'd0);

      for (int i = 0; i < 17; i++) begin
         inc = vt[i].inc;
         set_rd(vt[i].req, vt[i].addr, vt[i].clr);
         tick();
         check($sformatf("vec%0d vld_w", i),  64'(if_w.o_rd_vld),  64'(vt[i].vld));
         check($sformatf("vec%0d err_w", i),  64'(if_w.o_rd_err),  64'(vt[i].err));
         check($sformatf("vec%0d data_w", i), 64'(if_w.o_rd_data), 64'(vt[i].data));
         check($sformatf("vec%0d data_s", i), 64'(if_s.o_rd_data), 64'(vt[i].data));
         check($sformatf("vec%0d ovf_w", i),  64'(ovf_w),          64'd0);
      end
      inc = '0;
      set_rd(1'b0, '0, 1'b0);

      // All channels count 10 times, then clear-all with a coincident read of ch7.
      inc = '1;
      repeat (10) tick();
      clr_all = 1'b1;
      rd_chk("clr_all rd ch7", 6'd7, 1'b0, 8'd10, 8'd10);
      clr_all = 1'b0; inc = '0;
      check("clr_all ovf_w", 64'(ovf_w), 64'd0);
      rd_all_zero("after clr_all");

      // Overflow on ch3 (and ch0): wrap vs saturate.
      inc = 8'h09;
      repeat (255) tick();
      inc = '0;
      rd_chk("ch3 at max", 6'd3, 1'b0, 8'hFF, 8'hFF);
      check("ovf_w before wrap", 64'(ovf_w), 64'h00);
      check("ovf_s before wrap", 64'(ovf_s), 64'h00);
      inc = 8'h09;
      tick();
      inc = '0;
      check("ovf_w after 256", 64'(ovf_w), 64'h09);
      check("ovf_s after 256", 64'(ovf_s), 64'h09);
      rd_chk("ch3 wrapped", 6'd3, 1'b0, 8'h00, 8'hFF);
      rd_chk("ch3 rdclr",   6'd3, 1'b1, 8'h00, 8'hFF);
      check("ovf_w after rdclr", 64'(ovf_w), 64'h01);
      check("ovf_s after rdclr", 64'(ovf_s), 64'h01);
      rd_chk("ch3 after rdclr", 6'd3, 1'b0, 8'h00, 8'h00);
      inc = 8'h01;
      repeat (44) tick();
      inc = '0;
      rd_chk("ch0 after 300", 6'd0, 1'b0, 8'd44, 8'hFF);
      check("ovf_s ch0 sticky", 64'(ovf_s), 64'h01);
      check("ovf_w ch0 sticky", 64'(ovf_w), 64'h01);

      // Reset in the same cycle as a read request.
      set_rd(1'b1, 6'd0, 1'b0);
      inc = '1; reset = 1'b0;
      tick();
      check("rst+rd vld_w", 64'(if_w.o_rd_vld), 64'd0);
      check("rst+rd vld_s", 64'(if_s.o_rd_vld), 64'd0);
      reset = 1'b1; inc = '0;
      set_rd(1'b0, '0, 1'b0);
      tick();
      check("post rst vld_w", 64'(if_w.o_rd_vld), 64'd0);
      check("post rst vld_s", 64'(if_s.o_rd_vld), 64'd0);
      check("post rst ovf_w", 64'(ovf_w), 64'd0);
      check("post rst ovf_s", 64'(ovf_s), 64'd0);
      rd_all_zero("after mid reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stats_cntr_bank.md
STATS_CNTR_BANK -- requirements
Module: stats_cntr_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 8: number of counter channels, legal range 1..64.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: counter width in bits, legal range 8..48.
REQ-003 SHALL have parameter SAT_MODE, default 0: 0 = wrap to zero at max value, 1 = saturate at max value.
REQ-004 SHALL have parameter ADDR_WIDTH, default 6: read address width, which must satisfy 2^ADDR_WIDTH >= NUM_CNT.
REQ-005 gtx_clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 i_inc  input  NUM_CNT  per-channel increment strobe, one count per asserted cycle.
REQ-008 i_clr_all  input  1  clear every counter and every overflow flag.
REQ-009 i_rd_req  input  1  host read request, single-cycle pulse.
REQ-010 i_rd_addr  input  ADDR_WIDTH  channel to read.
REQ-011 i_rd_clr  input  1  qualifies i_rd_req as read-and-clear.
REQ-012 o_rd_data  output  CNT_WIDTH  read result.
REQ-013 o_rd_vld  output  1  one-cycle strobe marking o_rd_data valid.
REQ-014 o_rd_err  output  1  accompanies o_rd_vld when i_rd_addr >= NUM_CNT.
REQ-015 o_ovf  output  NUM_CNT  per-channel sticky flag: the counter wrapped or saturated.

Function
REQ-016 Each counter SHALL increment by 1 in the cycle after its i_inc bit is sampled high; any subset of channels may increment in the same cycle.
REQ-017 At max value (all ones) with i_inc high, the counter SHALL become 0 when SAT_MODE=0 and SHALL hold at all ones when SAT_MODE=1; in both modes o_ovf[ch] SHALL set.
REQ-018 o_ovf[ch] SHALL stay set until i_clr_all, or until a read-and-clear of that channel.
REQ-019 Read latency SHALL be exactly 1 cycle: o_rd_vld is high in the cycle after i_rd_req and low in every other cycle.
REQ-020 o_rd_data SHALL return the counter value held before the request cycle's increment is applied.
REQ-021 A read-and-clear with i_inc[ch] high in the same cycle SHALL leave the counter at 1 (the event is not lost); without i_inc the counter SHALL become 0; o_ovf[ch] SHALL clear in both cases.
REQ-022 A plain read (i_rd_clr=0) SHALL NOT alter counter or o_ovf state.
REQ-023 An out-of-range address SHALL return o_rd_data=0 with o_rd_err=1, and no counter shall change.
REQ-024 i_clr_all SHALL have priority over increments and read-clear: all counters and o_ovf become 0 next cycle, and same-cycle increments are dropped.
REQ-025 A read coincident with i_clr_all SHALL still return the pre-clear value.
REQ-026 o_rd_data SHALL hold its last value while o_rd_vld is low; o_rd_err SHALL be 0 while o_rd_vld is low.
REQ-027 There SHALL be no back-pressure: a read may be issued every cycle, with back-to-back requests serviced in order.

Reset
REQ-028 While reset=0 at a gtx_clk edge, all counters, o_ovf, o_rd_data, o_rd_vld and o_rd_err SHALL go to 0.
REQ-029 A read pending when reset asserts SHALL be discarded, so no o_rd_vld appears after reset releases.
REQ-030 Increments sampled during reset SHALL be ignored.

Structure
REQ-031 Package stats_pkg SHALL hold the default constants (NUM_CNT, CNT_WIDTH, ADDR_WIDTH) and the SAT_MODE encodings WRAP=0 and SAT=1.
REQ-032 Sub-module stats_cntr SHALL implement a single counter: inputs inc, clr and sat_mode; outputs val and ovf.
REQ-033 stats_cntr_bank SHALL instantiate stats_cntr NUM_CNT times via generate and add the read mux and read registers.

Verification
REQ-034 SAT_MODE=0, CNT_WIDTH=8: 256 increments on ch3 -> ch3 reads 0 with o_ovf[3]=1; a further read-and-clear returns 0 and clears o_ovf[3].
REQ-035 SAT_MODE=1, CNT_WIDTH=8: 300 increments on ch0 -> ch0 reads 255 (0xFF) with o_ovf[0]=1.
REQ-036 ch2 holds 5; read-and-clear of ch2 with i_inc[2]=1 in the same cycle -> o_rd_data=5 next cycle, and a subsequent read returns 1.
REQ-037 i_inc=all ones for 10 cycles, then i_clr_all together with a read of ch7 -> o_rd_data=10, and every channel afterwards reads 0.
REQ-038 NUM_CNT=8, read of address 9 -> o_rd_vld=1, o_rd_err=1, o_rd_data=0.
REQ-039 Reset asserted in the cycle of a read request -> no o_rd_vld afterwards and all channels read 0.
